// File: rtl/canvas_ctrl_if.sv
// canvas_ctrl_if: request/stream bundle between the canvas controller and
// its requesters.
//   master : mouse/cursor draw port, clear/snapshot pulses, classifier ready
//   slave  : canvas_ctrl side (draw ack, row stream, snapshot done)
`timescale 1ns/1ps
interface canvas_ctrl_if #(parameter int DIM = 32);
  localparam int CW = $clog2(DIM);

  // pixel write port (level request, held until ack)
  logic          iDrawReq;
  logic [CW-1:0] iDrawX;
  logic [CW-1:0] iDrawY;
  logic          iDrawVal;
  logic          oDrawAck;
  // one-cycle operation requests
  logic          iClearReq;
  logic          iSnapReq;
  // snapshot row stream (valid/ready)
  logic           oRowValid;
  logic [CW-1:0]  oRowIdx;
  logic [DIM-1:0] oRowData;
  logic           iRowReady;
  logic           oSnapDone;

  modport master (
    output iDrawReq, iDrawX, iDrawY, iDrawVal, iClearReq, iSnapReq, iRowReady,
    input  oDrawAck, oRowValid, oRowIdx, oRowData, oSnapDone
  );

  modport slave (
    input  iDrawReq, iDrawX, iDrawY, iDrawVal, iClearReq, iSnapReq, iRowReady,
    output oDrawAck, oRowValid, oRowIdx, oRowData, oSnapDone
  );
endinterface

// File: rtl/canvas_ctrl.sv
// canvas_ctrl: owns the DIM x DIM one-bit canvas and arbitrates pixel
// writes, the row-by-row clear sequencer and the snapshot row streamer.
// Ports:
//   iBusClk      clock, all state on rising edge
//   iRst         async active-high reset
//   bus          canvas_ctrl_if.slave (draw / clear / snapshot / stream)
//   oBusy        controller not in IDLE
//   oImage       live canvas, bit y*DIM+x
//   oPixelCount  number of set pixels, 0..DIM*DIM
`timescale 1ns/1ps
module canvas_ctrl #(
  parameter int DIM = 32
) (
  input  logic                      iBusClk,
  input  logic                      iRst,
  canvas_ctrl_if.slave              bus,
  output logic                      oBusy,
  output logic [DIM*DIM-1:0]        oImage,
  output logic [$clog2(DIM*DIM+1)-1:0] oPixelCount
);
  localparam int CW = $clog2(DIM);
  localparam int NW = $clog2(DIM*DIM+1);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic                     clr_pend, snap_pend;
  logic                     clr_start, snap_start, draw_go;
  logic                     last_row, cur_pix;
  logic [DIM-1:0][DIM-1:0]  canvas;   // [y][x]; flattens to bit y*DIM+x
  logic [NW-1:0]            pix_cnt;

  function automatic logic [NW-1:0] popcount(input logic [DIM-1:0] r);
    logic [NW-1:0] s;
    s = '0;
    for (int i = 0; i < DIM; i++) s = s + NW'(r[i]);
    return s;
  endfunction

  assign last_row    = (cnt == CW'(DIM-1));
  assign cur_pix     = canvas[bus.iDrawY][bus.iDrawX];
  assign oBusy       = (state != IDLE);
  assign oImage      = canvas;
  assign oPixelCount = pix_cnt;

  always_ff @(posedge iBusClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      cnt       <= '0;
      clr_pend  <= 1'b0;
      snap_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // a pulse seen while its flag is already set is absorbed
      clr_pend  <= (clr_pend  && !clr_start)  || (bus.iClearReq && !clr_pend);
      snap_pend <= (snap_pend && !snap_start) || (bus.iSnapReq  && !snap_pend);
    end
  end

  // IDLE priority: clear, then snapshot, then draw. Draws only ever see IDLE
  // with nothing pending, so the canvas stays frozen while streaming.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    clr_start     = 1'b0;
    snap_start    = 1'b0;
    draw_go       = 1'b0;
    bus.oRowValid = 1'b0;
    bus.oRowIdx   = '0;
    bus.oRowData  = '0;
    bus.oSnapDone = 1'b0;
    case (state)
      IDLE: begin
        if (clr_pend) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
          clr_start = 1'b1;
        end else if (snap_pend) begin
          state_nxt  = STREAM;
          cnt_nxt    = '0;
          snap_start = 1'b1;
        end else begin
          draw_go = bus.iDrawReq;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (last_row) state_nxt = IDLE;
      end
      STREAM: begin
        bus.oRowValid = 1'b1;
        bus.oRowIdx   = cnt;
        bus.oRowData  = canvas[cnt];
        if (bus.iRowReady) begin
          cnt_nxt = cnt + 1'b1;
          if (last_row) state_nxt = DONE;
        end
      end
      DONE: begin
        bus.oSnapDone = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    bus.oDrawAck = draw_go;
  end

  // Canvas and pixel count; count only moves when a pixel actually flips,
  // so it is bounded by 0..DIM*DIM without saturation logic.
  always_ff @(posedge iBusClk or posedge iRst) begin
    if (iRst) begin
      canvas  <= '0;
      pix_cnt <= '0;
    end else if (state == CLEAR) begin
      canvas[cnt] <= '0;
      pix_cnt     <= pix_cnt - popcount(canvas[cnt]);
    end else if (draw_go) begin
      canvas[bus.iDrawY][bus.iDrawX] <= bus.iDrawVal;
      if (bus.iDrawVal && !cur_pix)      pix_cnt <= pix_cnt + NW'(1);
      else if (!bus.iDrawVal && cur_pix) pix_cnt <= pix_cnt - NW'(1);
    end
  end
endmodule
